// File: rtl/bcd_addsub_serial_if.sv
// Start/done handshake bundle for the digit-serial BCD adder/subtractor.
// master drives operands and start; slave returns ready/done and results.
interface bcd_addsub_serial_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  mode;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  ready;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  cout;
  logic                  neg;
  logic                  err;

  modport master (
    output start, mode, a, b, cin,
    input  ready, done, result, cout, neg, err
  );

  modport slave (
    input  start, mode, a, b, cin,
    output ready, done, result, cout, neg, err
  );
endinterface

// File: rtl/bcd_addsub_serial.sv
// Digit-serial N-digit packed BCD add/subtract, sign-magnitude results.
// Ports: clk, rst_n (async low), bus (slave: start/mode/a/b/cin in; ready/done/result/cout/neg/err out).
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input logic                clk,
  input logic                rst_n,
  bcd_addsub_serial_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    PASS1,
    PASS2,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    t_q, t_d;
  logic            mode_q, mode_d;
  logic            c_q, c_d;
  logic            chk_q, chk_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    res_q, res_d;
  logic            cout_q, cout_d;
  logic            neg_q, neg_d;
  logic            err_q, err_d;

  logic [3:0]      x, y, dig;
  logic [4:0]      sum;
  logic            cn;
  logic            last;
  logic [W-1:0]    t_sh;

  function automatic logic bad_digits(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  // One decimal digit slice shared by both passes.
  // PASS2 feeds the nines complement of T with zero addend; the +1 comes in via c.
  always_comb begin
    x = a_q[3:0];
    y = mode_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    if (state_q == PASS2) begin
      x = 4'd9 - t_q[3:0];
      y = 4'd0;
    end
    sum = {1'b0, x} + {1'b0, y} + {4'd0, c_q};
    if (sum > 5'd9) begin
      dig = sum[3:0] + 4'd6;
      cn  = 1'b1;
    end else begin
      dig = sum[3:0];
      cn  = 1'b0;
    end
    // New digit enters at the MSD end so the LSD ends up at bits [3:0].
    t_sh = (t_q >> 4) | (W'(dig) << (4 * (DIGITS - 1)));
    last = (cnt_q == CW'(DIGITS - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    t_d     = t_q;
    mode_d  = mode_q;
    c_d     = c_q;
    chk_d   = chk_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    cout_d  = cout_q;
    neg_d   = neg_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = bus.mode;
          c_d     = bus.mode ? ~bus.cin : bus.cin;
          chk_d   = bad_digits(bus.a) | bad_digits(bus.b);
          t_d     = '0;
          cnt_d   = '0;
          state_d = PASS1;
        end
      end
      PASS1: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        t_d   = t_sh;
        c_d   = cn;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          cnt_d = '0;
          if (mode_q && !cn) begin
            // No final carry: T holds 10^N + D with D negative.
            c_d     = 1'b1;
            state_d = PASS2;
          end else begin
            state_d = DONE;
            res_d   = chk_q ? '0 : t_sh;
            cout_d  = ~chk_q & ~mode_q & cn;
            neg_d   = 1'b0;
            err_d   = chk_q;
          end
        end
      end
      PASS2: begin
        t_d   = t_sh;
        c_d   = cn;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          cnt_d   = '0;
          state_d = DONE;
          res_d   = chk_q ? '0 : t_sh;
          cout_d  = ~chk_q;
          neg_d   = ~chk_q;
          err_d   = chk_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
      mode_q  <= 1'b0;
      c_q     <= 1'b0;
      chk_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = res_q;
  assign bus.cout   = cout_q;
  assign bus.neg    = neg_q;
  assign bus.err    = err_q;

endmodule
